// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port round-robin arbiter and access sequencer for the byte-addressed
// 32-bit data memory. Port 0 serves the core load/store unit, port 1 a
// secondary master (DMA/debug loader). One transaction is in flight at a time:
// IDLE -> ACCESS -> DONE -> IDLE.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0    port 0 request, held stable until ack0
//   ack0/rdata0/err0         port 0 completion pulse, load data, misalignment flag
//   req1/we1/addr1/wdata1    port 1 request
//   ack1/rdata1/err1         port 1 completion
//   mem_addr/mem_wdata       memory address (low 2 bits cleared) and write data
//   mem_write                memory write enable, asserted only in ACCESS
//   mem_rdata                memory combinational read word
//   busy                     high while a transaction is in flight
//   gnt_id                   port number of the current or most recent grant
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              lastGnt_q, lastGnt_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              winner;
  logic              aligned;

  // On a tie the port that did not win last time is chosen; a lone requester
  // always wins. lastGnt resets to 1 so port 0 takes the first tie.
  assign winner  = (req0 & req1) ? ~lastGnt_q : req1;
  assign aligned = (addr_q[1:0] == 2'b00);

  // Next-state logic: requests are only looked at in IDLE, so a requester
  // that drops req mid-transaction still completes what was latched.
  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d     = winner;
          lastGnt_d = winner;
          we_d      = winner ? we1 : we0;
          addr_d    = winner ? addr1 : addr0;
          wdata_d   = winner ? wdata1 : wdata0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Ack/err are registered here so they appear during DONE.
        // Misaligned loads leave rdata untouched.
        if (gnt_q) begin
          ack1_d = 1'b1;
          err1_d = ~aligned;
          if (!we_q && aligned) rdata1_d = mem_rdata;
        end else begin
          ack0_d = 1'b1;
          err0_d = ~aligned;
          if (!we_q && aligned) rdata0_d = mem_rdata;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lastGnt_q <= 1'b1;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      lastGnt_q <= lastGnt_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // mem_write is decoded from the state register so it falls the instant rst
  // rises; all four bytes commit on the single edge closing ACCESS.
  assign mem_write = (state_q == ACCESS) & we_q & aligned;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small behavioural memory. Stimulus
// pushes the expected completion into a scoreboard queue; a monitor pops and
// compares whenever an ack appears.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, busy, gnt_id;

  logic [31:0] memArr [16];

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  assign mem_rdata = memArr[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_write) memArr[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ack actual ack0=%0b ack1=%0b required none", ack0, ack1);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("sb_ack_port", {30'd0, ack1, ack0}, monE.port ? 32'd2 : 32'd1);
        if (monE.port) begin
          checkOutput("sb_err1", {31'd0, err1}, {31'd0, monE.err});
          checkOutput("sb_rdata1", rdata1, monE.rdata);
          checkOutput("sb_idle_err0", {31'd0, err0}, 32'd0);
        end else begin
          checkOutput("sb_err0", {31'd0, err0}, {31'd0, monE.err});
          checkOutput("sb_rdata0", rdata0, monE.rdata);
          checkOutput("sb_idle_err1", {31'd0, err1}, 32'd0);
        end
      end
    end
  end

  // One transaction on one port, starting just after a rising edge. The ack
  // is expected at the third falling edge: edge k grants, k+1 is ACCESS,
  // k+2 is DONE.
  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expErr, input int expWrites);
    int writes = 0;
    int ackCycle = 0;
    exp_t e;
    e.port = port;
    e.rdata = expRdata;
    e.err = expErr;
    sbQ.push_back(e);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checkOutput("access_mem_addr", mem_addr, {addr[31:2], 2'b00});
        if (we) checkOutput("access_mem_wdata", mem_wdata, wdata);
      end
      if (mem_write) writes++;
      if (port ? ack1 : ack0) begin
        ackCycle = c;
        checkOutput("done_gnt_id", {31'd0, gnt_id}, {31'd0, port});
        checkOutput("done_busy", {31'd0, busy}, 32'd1);
        break;
      end
    end
    checkOutput("ack_latency", ackCycle, 3);
    checkOutput("write_cycles", writes, expWrites);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int ackCount;
    int lastAck;
    exp_t e;
    for (int i = 0; i < 16; i++) memArr[i] = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    checkOutput("rst_err", {30'd0, err1, err0}, 32'd0);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rdata0", rdata0, 32'd0);
    checkOutput("rst_rdata1", rdata1, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] store / load sequence");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    checkOutput("mem_0x10_stored", memArr[4], 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    checkOutput("rdata0_unchanged", rdata0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 0);
    checkOutput("rdata1_unchanged", rdata1, 32'hDEADBEEF);

    $display("[TB] misaligned accesses");
    applyStimulus(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 32'h12345678, 1'b1, 0);
    checkOutput("mem_0x10_intact", memArr[4], 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h22, 32'h0, 32'hDEADBEEF, 1'b1, 0);

    $display("[TB] idle window");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("idle_mem_write", {31'd0, mem_write}, 32'd0);
      checkOutput("idle_acks", {30'd0, ack1, ack0}, 32'd0);
    end
    @(posedge clk);
    #1;

    $display("[TB] reset during ACCESS");
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midop_write_before", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    checkOutput("midop_write_after", {31'd0, mem_write}, 32'd0);
    checkOutput("midop_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("midop_no_ack", {30'd0, ack1, ack0}, 32'd0);
    rst = 1'b0;
    checkOutput("midop_mem_unchanged", memArr[12], 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 1);
    checkOutput("post_reset_store", memArr[12], 32'hCAFEF00D);

    $display("[TB] simultaneous requests after reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      e.port = i[0];
      e.rdata = i[0] ? 32'h12345678 : 32'hDEADBEEF;
      e.err = 1'b0;
      sbQ.push_back(e);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    ackCount = 0;
    lastAck = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        checkOutput("rr_gnt_id", {31'd0, gnt_id}, ackCount % 2);
        checkOutput("rr_ack_spacing", c - lastAck, (ackCount == 0) ? 3 : 3);
        lastAck = c;
        ackCount++;
        if (ackCount == 4) break;
      end
    end
    checkOutput("rr_ack_count", ackCount, 4);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("sb_drained", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
